// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite fetch pipeline.
//   color_t  - 12-bit RGB444 pixel
//   hcount_t - 11-bit horizontal pixel count
//   vcount_t - 10-bit vertical line count
package sprite_pkg;
  localparam int COLOR_W   = 12;
  localparam int SCALE_MAX = 3;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [10:0]        hcount_t;
  typedef logic [9:0]         vcount_t;
endpackage

// File: rtl/sprite_fetch_pipe_delay.sv
// pipe_delay: synchronously-reset shift register.
//   clk, rst : clock, synchronous active-high reset
//   din      : W-bit input, sampled every cycle
//   dout     : din delayed by DEPTH cycles (DEPTH=0 is a plain wire)
// Every stage resets to RESET_VAL so the delayed bundle is well defined
// while the pipe refills after reset.
module pipe_delay #(
  parameter int             W         = 1,
  parameter int             DEPTH     = 1,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] stage_q;
      logic [DEPTH-1:0][W-1:0] stage_d;

      always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          stage_q <= {DEPTH{RESET_VAL}};
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/sprite_fetch_pipe.sv
// sprite_fetch_pipe: pixel-pipeline stage between VGA timing and the pins.
//   clk, rst                     : pixel clock, synchronous active-high reset
//   hcount_in, vcount_in         : raw pixel position from the timing generator
//   hsync_in, vsync_in, blank_in : raw timing strobes
//   pos_x_in, pos_y_in, scale_in : requested sprite origin / log2 zoom,
//                                  taken only on the vsync rising edge
//   mem_addr, mem_dout           : image memory read port (MEM_LATENCY cycles)
//   pixel_out, hsync_out,
//   vsync_out, blank_out         : aligned outputs, MEM_LATENCY+2 cycles late
module sprite_fetch_pipe
  import sprite_pkg::*;
#(
  parameter int     WIDTH       = 128,
  parameter int     HEIGHT      = 128,
  parameter int     MEM_LATENCY = 2,
  parameter color_t BG_COLOR    = 12'h000,
  parameter bit     KEY_EN      = 1'b0,
  parameter color_t KEY_COLOR   = 12'hF0F
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [10:0]                    hcount_in,
  input  logic [9:0]                     vcount_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           blank_in,
  input  logic [10:0]                    pos_x_in,
  input  logic [9:0]                     pos_y_in,
  input  logic [1:0]                     scale_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] mem_addr,
  input  logic [COLOR_W-1:0]             mem_dout,
  output logic [COLOR_W-1:0]             pixel_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           blank_out
);
  localparam int AW = $clog2(WIDTH*HEIGHT);

  // Bundle layout for the delay line: {in_sprite, hsync, vsync, blank}.
  localparam logic [3:0] BUNDLE_RST = 4'b0001;

  // Frame-synchronous shadow of the sprite placement.
  logic    vsync_prev_q, vsync_prev_d;
  hcount_t pos_x_q, pos_x_d;
  vcount_t pos_y_q, pos_y_d;
  logic [1:0] scale_q, scale_d;

  // Stage 1.
  logic signed [11:0] rel_x, rel_y;
  logic [31:0] ext_x, ext_y, lim_x, lim_y, col, row, addr_full;
  logic        in_sprite;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]  s1_q, s1_d;

  // Aligned with mem_dout.
  logic [3:0]  dly;

  // Output stage.
  color_t pixel_q, pixel_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;

  always_comb begin
    vsync_prev_d = vsync_in;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    scale_d      = scale_q;
    if (vsync_in && !vsync_prev_q) begin
      pos_x_d = pos_x_in;
      pos_y_d = pos_y_in;
      scale_d = scale_in;
    end
  end

  always_comb begin
    // Zero-extended operands keep the 12-bit difference exact; bit 11 is
    // the sign, so a pixel left of / above the sprite never wraps inside.
    rel_x = {1'b0, hcount_in} - {1'b0, pos_x_q};
    rel_y = {2'b0, vcount_in} - {2'b0, pos_y_q};
    ext_x = {20'd0, rel_x};
    ext_y = {20'd0, rel_y};
    lim_x = 32'(WIDTH)  << scale_q;
    lim_y = 32'(HEIGHT) << scale_q;
    in_sprite = !rel_x[11] && !rel_y[11] && (ext_x < lim_x) && (ext_y < lim_y);
    // Non-negative inside the sprite, so a logical shift equals >>>.
    col = ext_x >> scale_q;
    row = ext_y >> scale_q;
    addr_full = row * 32'(WIDTH) + col;
    mem_addr_d = in_sprite ? addr_full[AW-1:0] : '0;
    s1_d = {in_sprite, hsync_in, vsync_in, blank_in};
  end

  pipe_delay #(
    .W         (4),
    .DEPTH     (MEM_LATENCY),
    .RESET_VAL (BUNDLE_RST)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (s1_q),
    .dout (dly)
  );

  always_comb begin
    hsync_d = dly[2];
    vsync_d = dly[1];
    blank_d = dly[0];
    if (dly[0]) begin
      pixel_d = '0;
    end else if (!dly[3]) begin
      pixel_d = BG_COLOR;
    end else if (KEY_EN && (mem_dout == KEY_COLOR)) begin
      pixel_d = BG_COLOR;
    end else begin
      pixel_d = mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_q <= 1'b0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      scale_q      <= '0;
      mem_addr_q   <= '0;
      s1_q         <= BUNDLE_RST;
      pixel_q      <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      blank_q      <= 1'b1;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      scale_q      <= scale_d;
      mem_addr_q   <= mem_addr_d;
      s1_q         <= s1_d;
      pixel_q      <= pixel_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      blank_q      <= blank_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign pixel_out = pixel_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;
  assign blank_out = blank_q;
endmodule

// File: tb/tb_sprite_fetch_pipe.sv
module tb_sprite_fetch_pipe;
  localparam logic [11:0] BG  = 12'h123;
  localparam logic [11:0] KEY = 12'hF0F;
  localparam int          LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  logic [10:0] pos_x_in;
  logic [9:0]  pos_y_in;
  logic [1:0]  scale_in;
  logic [13:0] mem_addr;
  logic [11:0] mem_dout;
  logic [11:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out;

  always #5 clk = ~clk;

  sprite_fetch_pipe #(
    .WIDTH(128), .HEIGHT(128), .MEM_LATENCY(2),
    .BG_COLOR(BG), .KEY_EN(1'b1), .KEY_COLOR(KEY)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .scale_in(scale_in),
    .mem_addr(mem_addr), .mem_dout(mem_dout),
    .pixel_out(pixel_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .blank_out(blank_out)
  );

  // Behavioural image memory, two-cycle read latency.
  logic [11:0] mem [16384];
  logic [11:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[mem_addr];
    rd2 <= rd1;
  end
  assign mem_dout = rd2;

  typedef struct {
    int          due;
    logic [14:0] out;   // {pixel, hsync, vsync, blank}
  } exp_t;

  exp_t        exp_q[$];
  logic [14:0] obs_hist [int];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // Reference model shadow state.
  int sx = 0, sy = 0, ss = 0;
  bit vprev = 1'b0;

  // Drive one pixel, push its expected output, advance one clock.
  task automatic tick(input int h, input int v, input bit vs, input bit bl);
    int rx, ry, a;
    bit ins, hs;
    logic [11:0] d, pix;
    exp_t e;
    @(negedge clk);
    hs = 1'($urandom_range(0, 1));
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    blank_in  = bl;
    rx  = h - sx;
    ry  = v - sy;
    ins = (rx >= 0) && (rx < (128 << ss)) && (ry >= 0) && (ry < (128 << ss));
    a   = ins ? ((ry >> ss) * 128 + (rx >> ss)) : 0;
    d   = mem[a];
    if (bl)                    pix = 12'h000;
    else if (!ins || d == KEY) pix = BG;
    else                       pix = d;
    e.due = cyc + LAT;
    e.out = {pix, hs, vs, bl};
    exp_q.push_back(e);
    if (vs && !vprev) begin
      sx = int'(pos_x_in);
      sy = int'(pos_y_in);
      ss = int'(scale_in);
    end
    vprev = vs;
    @(posedge clk);
    #1;
    cyc++;
    obs_hist[cyc] = {pixel_out, hsync_out, vsync_out, blank_out};
  endtask

  task automatic latch(input int px, input int py, input int sc);
    pos_x_in = 11'(px);
    pos_y_in = 10'(py);
    scale_in = 2'(sc);
    tick(0, 0, 1'b0, 1'b1);
    tick(0, 0, 1'b1, 1'b1);
    tick(0, 0, 1'b0, 1'b1);
  endtask

  task automatic model_reset();
    sx = 0; sy = 0; ss = 0; vprev = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b1; vsync_in = 1'b0; blank_in = 1'b0;
    pos_x_in = '0; pos_y_in = '0; scale_in = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL rst_pixel got=%h exp=000", pixel_out); end
    total++; if (blank_out !== 1'b1) begin bad++; $display("FAIL rst_blank got=%b exp=1", blank_out); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("FAIL rst_hsync got=%b exp=0", hsync_out); end
    total++; if (vsync_out !== 1'b0) begin bad++; $display("FAIL rst_vsync got=%b exp=0", vsync_out); end
    total++; if (mem_addr !== 14'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", mem_addr); end
    model_reset();
    rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick(0, 0, 1'b0, 1'b0);
      total++;
      if (blank_out !== (i < LAT)) begin
        bad++; $display("FAIL rst_refill cycle=%0d got=%b exp=%b", i, blank_out, (i < LAT));
      end
    end
    $display("test_reset done cyc=%0d", cyc);
  endtask

  task automatic test_addr_latency();
    exp_t e;
    int c;
    latch(0, 0, 0);
    tick(5, 3, 1'b0, 1'b0);
    c = cyc;
    total++; if (mem_addr !== 14'd389) begin bad++; $display("FAIL addr_389 got=%0d exp=389", mem_addr); end
    tick(7, 9, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd1159) begin bad++; $display("FAIL addr_1159 got=%0d exp=1159", mem_addr); end
    for (int i = 0; i < LAT; i++) tick(0, 0, 1'b0, 1'b1);
    total++; if (obs_hist[c + LAT - 1][14:3] !== 12'hABC) begin bad++; $display("FAIL latency_pixel got=%h exp=abc", obs_hist[c + LAT - 1][14:3]); end
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front(); total++;
      if (obs_hist[e.due] !== e.out) begin bad++; $display("FAIL addr_stream cyc=%0d got=%h exp=%h", e.due, obs_hist[e.due], e.out); end
    end
    $display("test_addr_latency done cyc=%0d", cyc);
  endtask

  task automatic test_shadow_latch();
    exp_t e;
    pos_x_in = 11'd100;
    tick(5, 3, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd389) begin bad++; $display("FAIL shadow_hold got=%0d exp=389", mem_addr); end
    latch(100, 0, 0);
    tick(105, 3, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd389) begin bad++; $display("FAIL shadow_new got=%0d exp=389", mem_addr); end
    tick(5, 3, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd0) begin bad++; $display("FAIL shadow_outside got=%0d exp=0", mem_addr); end
    for (int i = 0; i < LAT; i++) tick(0, 0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front(); total++;
      if (obs_hist[e.due] !== e.out) begin bad++; $display("FAIL shadow_stream cyc=%0d got=%h exp=%h", e.due, obs_hist[e.due], e.out); end
    end
    $display("test_shadow_latch done cyc=%0d", cyc);
  endtask

  task automatic test_zoom();
    exp_t e;
    latch(10, 20, 1);
    tick(13, 25, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd257) begin bad++; $display("FAIL zoom_257 got=%0d exp=257", mem_addr); end
    tick(265, 25, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd383) begin bad++; $display("FAIL zoom_col127 got=%0d exp=383", mem_addr); end
    tick(266, 25, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd0) begin bad++; $display("FAIL zoom_right got=%0d exp=0", mem_addr); end
    tick(9, 25, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd0) begin bad++; $display("FAIL zoom_left got=%0d exp=0", mem_addr); end
    for (int i = 0; i < LAT; i++) tick(0, 0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front(); total++;
      if (obs_hist[e.due] !== e.out) begin bad++; $display("FAIL zoom_stream cyc=%0d got=%h exp=%h", e.due, obs_hist[e.due], e.out); end
    end
    $display("test_zoom done cyc=%0d", cyc);
  endtask

  task automatic test_clip_edge();
    exp_t e;
    pos_x_in = 11'd2000; pos_y_in = 10'd0; scale_in = 2'd0;
    tick(2047, 0, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd0) begin bad++; $display("FAIL clip_old got=%0d exp=0", mem_addr); end
    // vsync edge during active video: old placement on this pixel.
    tick(2047, 0, 1'b1, 1'b0);
    total++; if (mem_addr !== 14'd0) begin bad++; $display("FAIL edge_same_cycle got=%0d exp=0", mem_addr); end
    tick(2047, 0, 1'b1, 1'b0);
    total++; if (mem_addr !== 14'd47) begin bad++; $display("FAIL clip_col47 got=%0d exp=47", mem_addr); end
    latch(10, 0, 0);
    tick(5, 0, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd0) begin bad++; $display("FAIL clip_neg got=%0d exp=0", mem_addr); end
    tick(12, 0, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd2) begin bad++; $display("FAIL clip_in got=%0d exp=2", mem_addr); end
    for (int i = 0; i < LAT; i++) tick(0, 0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front(); total++;
      if (obs_hist[e.due] !== e.out) begin bad++; $display("FAIL clip_stream cyc=%0d got=%h exp=%h", e.due, obs_hist[e.due], e.out); end
    end
    $display("test_clip_edge done cyc=%0d", cyc);
  endtask

  task automatic test_blank_key();
    exp_t e;
    int cb, ck, cn;
    latch(0, 0, 0);
    tick(5, 3, 1'b0, 1'b1);
    cb = cyc;
    total++; if (mem_addr !== 14'd389) begin bad++; $display("FAIL blank_addr got=%0d exp=389", mem_addr); end
    tick(10, 0, 1'b0, 1'b0);
    ck = cyc;
    tick(11, 0, 1'b0, 1'b0);
    cn = cyc;
    for (int i = 0; i < LAT; i++) tick(0, 0, 1'b0, 1'b1);
    total++; if (obs_hist[cb + LAT - 1][14:3] !== 12'h000) begin bad++; $display("FAIL blank_pixel got=%h exp=000", obs_hist[cb + LAT - 1][14:3]); end
    total++; if (obs_hist[ck + LAT - 1][14:3] !== BG) begin bad++; $display("FAIL key_hit got=%h exp=%h", obs_hist[ck + LAT - 1][14:3], BG); end
    total++; if (obs_hist[cn + LAT - 1][14:3] !== 12'hF0E) begin bad++; $display("FAIL key_miss got=%h exp=f0e", obs_hist[cn + LAT - 1][14:3]); end
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front(); total++;
      if (obs_hist[e.due] !== e.out) begin bad++; $display("FAIL key_stream cyc=%0d got=%h exp=%h", e.due, obs_hist[e.due], e.out); end
    end
    $display("test_blank_key done cyc=%0d", cyc);
  endtask

  task automatic test_midframe_reset();
    exp_t e;
    latch(50, 40, 2);
    tick(60, 50, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (blank_out !== 1'b1) begin bad++; $display("FAIL mid_rst_blank got=%b exp=1", blank_out); end
    model_reset();
    rst = 1'b0;
    tick(5, 3, 1'b0, 1'b0);
    total++; if (mem_addr !== 14'd389) begin bad++; $display("FAIL mid_rst_shadow got=%0d exp=389", mem_addr); end
    for (int i = 0; i < LAT; i++) tick(0, 0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front(); total++;
      if (obs_hist[e.due] !== e.out) begin bad++; $display("FAIL mid_rst_stream cyc=%0d got=%h exp=%h", e.due, obs_hist[e.due], e.out); end
    end
    $display("test_midframe_reset done cyc=%0d", cyc);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 12'(i * 37 + 5);
    mem[389] = 12'hABC;
    mem[10]  = 12'hF0F;
    mem[11]  = 12'hF0E;
    test_reset();
    test_addr_latency();
    test_shadow_latch();
    test_zoom();
    test_clip_edge();
    test_blank_key();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_fetch_pipe.md
Name: sprite_fetch_pipe

Overview:
- Pixel-pipeline stage between the VGA timing generator and the VGA output pins.
- Takes raw hcount/vcount/sync/blank and produces the sprite image-memory read address. Accepts read data back after a fixed memory latency.
- Emits a 12-bit pixel plus hsync/vsync/blank, all delay-matched so they are mutually aligned.
- Replaces ad-hoc address math and hand-sized pipes in the top level; adds frame-synchronous position/zoom updates and colour-key transparency.

Parameters:
- WIDTH, 128, sprite width in memory pixels.
- HEIGHT, 128, sprite height in memory pixels.
- MEM_LATENCY, 2, cycles from mem_addr change to matching mem_dout.
- BG_COLOR, 12'h000, colour outside the sprite.
- KEY_EN, 0, 1 enables colour-key transparency.
- KEY_COLOR, 12'hF0F, sprite colour treated as transparent when KEY_EN=1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- hcount_in  in  11  horizontal pixel count.
- vcount_in  in  10  vertical line count.
- hsync_in  in  1  active-high hsync from timing generator.
- vsync_in  in  1  active-high vsync.
- blank_in  in  1  1 = outside active video.
- pos_x_in  in  11  requested sprite left edge.
- pos_y_in  in  10  requested sprite top edge.
- scale_in  in  2  requested zoom, log2 (0..3).
- mem_addr  out  $clog2(WIDTH*HEIGHT)  image memory read address.
- mem_dout  in  12  image memory read data.
- pixel_out  out  12  RGB444 pixel.
- hsync_out  out  1  delayed hsync, same polarity as input.
- vsync_out  out  1  delayed vsync, same polarity as input.
- blank_out  out  1  delayed blank.

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous, active-high (rst).
- Latency: LATENCY = MEM_LATENCY + 2. Inputs sampled at cycle t produce pixel_out/hsync_out/vsync_out/blank_out at t+LATENCY (4 by default).
- Reset values:
  - pixel_out=0, mem_addr=0, hsync_out=0, vsync_out=0, blank_out=1.
  - All delay-line stages cleared to the same values, so blank_out stays 1 for LATENCY cycles after rst deasserts.
  - Shadow registers cleared: pos_x=0, pos_y=0, scale=0.
  - Reset mid-frame gives the same result; there is no partial-frame recovery.
- Shadow latch:
  - pos_x_in, pos_y_in and scale_in are captured only on the vsync rising edge, i.e. the cycle where vsync_in=1 and the registered vsync_in from the previous cycle was 0.
  - At all other times the shadow registers hold, so there is no mid-frame tearing.
  - Edge detection uses a registered vsync_in, reset to 0.
- Stage 1 (registered at t+1):
  - rel_x = hcount_in - pos_x and rel_y = vcount_in - pos_y, both 12-bit signed.
  - in_sprite = rel_x >= 0 and rel_x < (WIDTH<<scale) and rel_y >= 0 and rel_y < (HEIGHT<<scale).
  - No wrap-around: a sprite partly beyond the right/bottom edge is clipped, and a negative rel is outside.
  - mem_addr = (rel_y>>>scale)*WIDTH + (rel_x>>>scale) when in_sprite, else 0.
  - Products are computed at full width, then truncated to the address width. The in-range check guarantees no overflow.
- Delay lines: in_sprite, hsync, vsync and blank are delayed so they arrive alongside mem_dout at t+1+MEM_LATENCY.
- Output stage (registered at t+LATENCY), in priority order:
  - if blank: pixel_out = 0;
  - else if !in_sprite: BG_COLOR;
  - else if KEY_EN and mem_dout==KEY_COLOR: BG_COLOR;
  - else mem_dout.
- Simultaneous events: a vsync edge coinciding with active pixels (not legal VGA timing) still latches, and the new values apply from the next cycle's stage-1 computation.

Decomposition:
- Package sprite_pkg: typedef color_t (logic [11:0]), hcount_t (11), vcount_t (10), constants COLOR_W=12 and SCALE_MAX=3.
- One sub-module pipe_delay #(W, DEPTH, RESET_VAL) for the synchronously-reset shift register. Instantiate it for the sync/blank/in_sprite bundle.
- Address math and the output mux live in sprite_fetch_pipe itself.

Test Plan:
- Reset: hold rst 3 cycles with blank_in=0 -> pixel_out=0, blank_out=1, hsync_out/vsync_out=0; after release, blank_out stays 1 for exactly 4 cycles, then follows blank_in.
- Address/latency: pos (0,0), scale 0, hcount=5, vcount=3 at t -> mem_addr=389 at t+1; behavioural memory (latency 2) returns 12'hABC -> pixel_out=12'hABC at t+4, hsync_out equals hsync_in delayed by 4.
- Shadow latch: drive pos_x_in=100 mid-frame -> hcount=5, vcount=3 still reads addr 389 until the next vsync rising edge; afterwards hcount=105 gives mem_addr=389 and hcount=5 gives BG_COLOR.
- Zoom: latched pos (10,20), scale 1: hcount=13, vcount=25 -> mem_addr=257; hcount=265 in sprite (column 127); hcount=266 -> mem_addr=0, pixel BG_COLOR.
- Clipping/blank: pos_x=2000, hcount=2047 -> in sprite, column 47; pos_x=10, hcount=5 -> outside, mem_addr=0; any pixel with blank_in=1 -> pixel_out=0 regardless of memory data.
- Colour key: KEY_EN=1, memory returns 12'hF0F inside sprite -> pixel_out=BG_COLOR; returns 12'hF0E -> pixel_out=12'hF0E.
